// File: rtl/fwd_scoreboard.sv
// Operand forwarding selects plus a per-register pending table for
// long-latency writes, with stall accounting and a stall watchdog.
package riscv_pkg;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } forward_src_e;
endpackage

module fwd_scoreboard
    import riscv_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int MAX_PEND = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_SRC-1:0][REG_ADDR_WIDTH-1:0]  src_addr,
    input  logic [NUM_SRC-1:0]                      src_used,
    input  logic [REG_ADDR_WIDTH-1:0]               ex_mem_rd_addr,
    input  logic                                    ex_mem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0]               mem_wb_rd_addr,
    input  logic                                    mem_wb_reg_write,
    input  logic                                    issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0]               issue_rd,
    input  logic                                    cpl_valid,
    input  logic [REG_ADDR_WIDTH-1:0]               cpl_rd,
    input  logic                                    flush,
    output forward_src_e [NUM_SRC-1:0]              forward_sel,
    output logic                                    stall,
    output logic                                    issue_ready,
    output logic [31:0]                             stall_count,
    output logic                                    hazard_timeout,
    output logic                                    sb_error
);

    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;
    localparam int CW       = $clog2(MAX_PEND + 1);
    localparam int RW       = $clog2(TIMEOUT + 1);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [CW-1:0]       pend_cnt_q;
    logic [CW-1:0]       pend_cnt_d;
    logic [31:0]         stall_cnt_q;
    logic [RW-1:0]       run_q;
    logic [RW-1:0]       run_d;
    logic                timeout_q;
    logic                err_q;

    logic [NUM_SRC-1:0]  port_stall;
    logic                issue_acc;
    logic                cpl_clr;
    logic                set_new;
    logic                err_set;

    always_comb begin
        for (int p = 0; p < NUM_SRC; p++) begin
            forward_sel[p] = FWD_NONE;
            if (ex_mem_reg_write && ex_mem_rd_addr != '0 &&
                ex_mem_rd_addr == src_addr[p]) begin
                forward_sel[p] = FWD_MEM;
            end else if (mem_wb_reg_write && mem_wb_rd_addr != '0 &&
                         mem_wb_rd_addr == src_addr[p]) begin
                forward_sel[p] = FWD_WB;
            end
        end
    end

    // A completion landing this cycle is already on the WB bypass.
    always_comb begin
        for (int p = 0; p < NUM_SRC; p++) begin
            port_stall[p] = src_used[p] && src_addr[p] != '0 &&
                            pending_q[src_addr[p]] &&
                            !(cpl_valid && cpl_rd == src_addr[p]);
        end
    end

    assign stall       = |port_stall;
    assign issue_ready = (pend_cnt_q != CW'(MAX_PEND));

    assign issue_acc = issue_valid && issue_ready && !flush &&
                       issue_rd != '0;
    assign cpl_clr   = cpl_valid && pending_q[cpl_rd] &&
                       !(issue_acc && issue_rd == cpl_rd);
    assign set_new   = issue_acc && !pending_q[issue_rd];
    assign err_set   = (cpl_valid && !pending_q[cpl_rd]) ||
                       (issue_valid && !issue_ready);

    always_comb begin
        pending_d = pending_q;
        if (cpl_clr) begin
            pending_d[cpl_rd] = 1'b0;
        end
        if (issue_acc) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
        pend_cnt_d = pend_cnt_q + CW'(set_new) - CW'(cpl_clr);
    end

    always_comb begin
        run_d = '0;
        if (stall) begin
            run_d = (run_q == RW'(TIMEOUT)) ? run_q : run_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            pend_cnt_q  <= '0;
            stall_cnt_q <= '0;
            run_q       <= '0;
            timeout_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
            run_q      <= run_d;
            if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (run_d == RW'(TIMEOUT)) begin
                timeout_q <= 1'b1;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign stall_count    = stall_cnt_q;
    assign hazard_timeout = timeout_q;
    assign sb_error       = err_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard: directed hazard scenarios
// followed by a constrained-random phase against a behavioural model.
module tb_fwd_scoreboard;
    import riscv_pkg::*;

    typedef enum int {K_STALL, K_READY, K_FWD0, K_FWD1, K_SCNT, K_TO, K_ERR} kind_e;
    typedef struct {
        kind_e       k;
        logic [31:0] v;
        string       tag;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0][4:0]     src_addr;
    logic [1:0]          src_used;
    logic [4:0]          ex_mem_rd_addr;
    logic                ex_mem_reg_write;
    logic [4:0]          mem_wb_rd_addr;
    logic                mem_wb_reg_write;
    logic                issue_valid;
    logic [4:0]          issue_rd;
    logic                cpl_valid;
    logic [4:0]          cpl_rd;
    logic                flush;
    forward_src_e [1:0]  forward_sel;
    logic                stall;
    logic                issue_ready;
    logic [31:0]         stall_count;
    logic                hazard_timeout;
    logic                sb_error;

    fwd_scoreboard #(.NUM_SRC(2), .MAX_PEND(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .src_addr(src_addr), .src_used(src_used),
        .ex_mem_rd_addr(ex_mem_rd_addr), .ex_mem_reg_write(ex_mem_reg_write),
        .mem_wb_rd_addr(mem_wb_rd_addr), .mem_wb_reg_write(mem_wb_reg_write),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .cpl_valid(cpl_valid), .cpl_rd(cpl_rd), .flush(flush),
        .forward_sel(forward_sel), .stall(stall), .issue_ready(issue_ready),
        .stall_count(stall_count), .hazard_timeout(hazard_timeout),
        .sb_error(sb_error)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t q[$];

    bit          m_pend[32];
    int          m_cnt;
    logic [31:0] m_scnt;
    int          m_run;
    bit          m_to;
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] observe(input kind_e k);
        case (k)
            K_STALL: return 32'(stall);
            K_READY: return 32'(issue_ready);
            K_FWD0:  return 32'(forward_sel[0]);
            K_FWD1:  return 32'(forward_sel[1]);
            K_SCNT:  return stall_count;
            K_TO:    return 32'(hazard_timeout);
            default: return 32'(sb_error);
        endcase
    endfunction

    task automatic push(input kind_e k, input logic [31:0] v, input string tag);
        exp_t e;
        e.k = k;
        e.v = v;
        e.tag = tag;
        q.push_back(e);
    endtask

    function automatic logic [31:0] m_fwd(input int p);
        if (ex_mem_reg_write && ex_mem_rd_addr != 0 && ex_mem_rd_addr == src_addr[p])
            return 32'(FWD_MEM);
        if (mem_wb_reg_write && mem_wb_rd_addr != 0 && mem_wb_rd_addr == src_addr[p])
            return 32'(FWD_WB);
        return 32'(FWD_NONE);
    endfunction

    function automatic bit m_stall();
        bit s = 0;
        for (int p = 0; p < 2; p++) begin
            if (src_used[p] && src_addr[p] != 0 && m_pend[src_addr[p]] &&
                !(cpl_valid && cpl_rd == src_addr[p]))
                s = 1;
        end
        return s;
    endfunction

    task automatic model_update();
        bit ready, acc, st;
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_cnt = 0; m_scnt = 0; m_run = 0; m_to = 0; m_err = 0;
            return;
        end
        ready = (m_cnt != 4);
        st = m_stall();
        acc = issue_valid && ready && !flush && issue_rd != 0;
        if (cpl_valid && !m_pend[cpl_rd]) m_err = 1;
        if (issue_valid && !ready) m_err = 1;
        if (cpl_valid && m_pend[cpl_rd] && !(acc && issue_rd == cpl_rd))
            m_pend[cpl_rd] = 0;
        if (acc) m_pend[issue_rd] = 1;
        m_cnt = 0;
        foreach (m_pend[i]) m_cnt += int'(m_pend[i]);
        if (st) begin
            if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
            m_run++;
            if (m_run >= 16) m_to = 1;
        end else begin
            m_run = 0;
        end
    endtask

    task automatic cyc();
        exp_t e;
        if (!rst) begin
            push(K_STALL, 32'(m_stall()), "m_stall");
            push(K_READY, 32'(m_cnt != 4), "m_ready");
            push(K_FWD0, m_fwd(0), "m_fwd0");
            push(K_FWD1, m_fwd(1), "m_fwd1");
            push(K_SCNT, m_scnt, "m_scnt");
            push(K_TO, 32'(m_to), "m_timeout");
            push(K_ERR, 32'(m_err), "m_err");
        end else begin
            q.delete();
        end
        #3;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk(e.tag, observe(e.k), e.v);
        end
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic idle();
        src_used = '0;
        ex_mem_reg_write = 0; mem_wb_reg_write = 0;
        issue_valid = 0; cpl_valid = 0; flush = 0;
    endtask

    task automatic do_issue(input logic [4:0] rd);
        issue_valid = 1; issue_rd = rd; cyc(); idle();
    endtask

    task automatic do_cpl(input logic [4:0] rd);
        cpl_valid = 1; cpl_rd = rd; cyc(); idle();
    endtask

    initial begin
        rst = 1; src_addr = '0; ex_mem_rd_addr = 0; mem_wb_rd_addr = 0;
        issue_rd = 0; cpl_rd = 0;
        idle();
        cyc();
        rst = 0;
        push(K_STALL, 0, "rst_stall");
        push(K_READY, 1, "rst_ready");
        push(K_SCNT, 0, "rst_scnt");
        push(K_TO, 0, "rst_timeout");
        push(K_ERR, 0, "rst_err");
        cyc();

        src_addr[0] = 5; ex_mem_rd_addr = 5; ex_mem_reg_write = 1;
        mem_wb_rd_addr = 5; mem_wb_reg_write = 1;
        push(K_FWD0, 32'(FWD_MEM), "fwd_mem_prio");
        cyc();
        ex_mem_rd_addr = 0;
        push(K_FWD0, 32'(FWD_WB), "fwd_wb_x0");
        cyc();
        idle();

        do_issue(7);
        src_used[1] = 1; src_addr[1] = 7;
        repeat (3) begin
            push(K_STALL, 1, "raw_stall");
            cyc();
        end
        cpl_valid = 1; cpl_rd = 7; mem_wb_reg_write = 1; mem_wb_rd_addr = 7;
        push(K_STALL, 0, "cpl_release");
        push(K_FWD1, 32'(FWD_WB), "cpl_fwd_wb");
        cyc();
        idle();

        for (int r = 1; r <= 4; r++) do_issue(5'(r));
        push(K_READY, 0, "full_not_ready");
        push(K_ERR, 0, "full_no_err");
        cyc();
        do_issue(10);
        src_used[0] = 1; src_addr[0] = 10;
        push(K_ERR, 1, "ovf_err");
        push(K_STALL, 0, "ovf_ignored");
        cyc();
        idle();
        do_cpl(2);
        push(K_READY, 1, "ready_again");
        cyc();
        do_cpl(1); do_cpl(3); do_cpl(4);

        do_issue(9);
        issue_valid = 1; issue_rd = 9; cpl_valid = 1; cpl_rd = 9;
        cyc();
        idle();
        src_used[0] = 1; src_addr[0] = 9;
        push(K_STALL, 1, "iss_cpl_keep");
        cyc();
        idle();
        do_cpl(9);
        do_issue(11); do_issue(12); do_issue(13);
        do_issue(0);
        push(K_READY, 1, "rd0_no_bit");
        cyc();
        flush = 1;
        do_issue(14);
        src_used[0] = 1; src_addr[0] = 14;
        push(K_READY, 1, "flush_no_bit");
        push(K_STALL, 0, "flush_squash");
        cyc();
        idle();
        do_cpl(11); do_cpl(12); do_cpl(13);

        rst = 1; cyc(); rst = 0;
        do_issue(20);
        src_used[0] = 1; src_addr[0] = 20;
        repeat (15) cyc();
        push(K_TO, 0, "timeout_early");
        cyc();
        src_used[0] = 0;
        push(K_TO, 1, "timeout_set");
        push(K_SCNT, 16, "scnt_16");
        cyc();
        do_cpl(20);
        push(K_TO, 1, "timeout_sticky");
        cyc();
        rst = 1; cyc(); rst = 0;
        push(K_SCNT, 0, "rst2_scnt");
        push(K_TO, 0, "rst2_timeout");
        push(K_ERR, 0, "rst2_err");
        push(K_READY, 1, "rst2_ready");
        cyc();

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int p = 0; p < 2; p++) begin
                src_used[p] = ($urandom_range(0, 3) != 0);
                src_addr[p] = 5'($urandom_range(0, 6));
            end
            ex_mem_reg_write = $urandom_range(0, 1) == 1;
            ex_mem_rd_addr = 5'($urandom_range(0, 6));
            mem_wb_reg_write = $urandom_range(0, 1) == 1;
            mem_wb_rd_addr = 5'($urandom_range(0, 6));
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd = 5'($urandom_range(0, 6));
            cpl_valid = ($urandom_range(0, 2) == 0);
            cpl_rd = 5'($urandom_range(1, 6));
            flush = ($urandom_range(0, 9) == 0);
            cyc();
        end
        rst = 0;
        idle();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
